mem_wb_pipe: RTL and testbench
==============================

# mem_wb_pipe

Parametrised memory-access stage for the five-stage core, placed between the EXE/MEM and MEM/WB boundaries. It drives a handshaked data-memory port with byte enables, aligns and sign- or zero-extends loads, and stalls upstream while memory is busy. It owns a registered MEM/WB pipeline register feeding writeback, including the PC+4 link value for JAL/JALR.

## Interface
- XLEN, 32, datapath width; must be 32 or 64
- ADDR_W, 11, data-memory byte-address width
- PC_W, 15, width of the incoming PC
- REG_W, 5, register-index width
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  EXE/MEM slot holds a real instruction
- ex_mem_read / ex_mem_write  in  1 each  load / store request (never both set)
- ex_funct3  in  3  bits [1:0]: size (00 byte, 01 half, 10 word, 11 dword when XLEN=64); bit 2: unsigned load
- ex_alu_result  in  XLEN  effective address / ALU value
- ex_write_data  in  XLEN  store data, LSB-justified
- ex_mem_to_reg  in  2  writeback select, passed through
- ex_reg_write  in  1  register write enable, passed through
- ex_rd  in  REG_W  destination register
- ex_pc  in  PC_W  instruction PC
- mem_stall  out  1  upstream must hold all ex_* stable and freeze
- dmem_req  out  1  memory request valid
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_W  byte address, low bits aligned to size
- dmem_be  out  XLEN/8  byte-lane enables
- dmem_wdata  out  XLEN  lane-replicated store data
- dmem_rdata  in  XLEN  read data, valid with dmem_ack
- dmem_ack  in  1  request complete this cycle
- wb_valid, wb_reg_write  out  1 each  registered
- wb_mem_to_reg  out  2;  wb_rd  out  REG_W;  wb_read_data, wb_alu_result, wb_pc_plus4  out  XLEN (all registered)
- wb_misalign  out  1;  wb_bad_addr  out  XLEN  (present only with MEM_MISALIGN_TRAP_EN)

## Operation
- Two-state FSM: IDLE, WAIT.
- IDLE, memory op (ex_valid & (read | write)): dmem_req=1 combinationally. If dmem_ack is high the same cycle, the op completes. Otherwise go to WAIT.
- WAIT: dmem_req stays 1 with fields rebuilt from the held ex_* inputs; mem_stall=1; go to IDLE on dmem_ack.
- Non-memory or invalid slot: no request, completes in the same cycle.
- Store lanes: lane = addr[LANE_W-1:0], where LANE_W = log2(XLEN/8). dmem_be has 1/2/4/8 consecutive bits starting at lane. Store data is replicated to every size-aligned slot.
- Loads: shift dmem_rdata right by 8×lane, truncate to size, then zero-extend (funct3[2]=1) or sign-extend.
- wb_pc_plus4 = zero-extend(ex_pc) + 4, modulo 2^XLEN.
- dmem_ack in IDLE with no request is ignored.

## Timing
- Reset: state IDLE, dmem_req 0, all wb_* outputs 0.
- Completing cycle: the MEM/WB register loads the instruction's results on the next edge. A zero-wait memory gives 1-cycle latency; N wait cycles add N cycles.
- While mem_stall=1, the MEM/WB register loads a bubble each edge: wb_valid=0, wb_reg_write=0, other fields hold.
- Back-to-back memory ops with same-cycle ack issue every cycle with no bubble.
- Reset asserted mid-WAIT: the request is dropped immediately and state goes to IDLE. A late dmem_ack is ignored.
- mem_stall is combinational from state and dmem_ack: it is 0 in the cycle ack arrives.

## Configuration
- MEM_MISALIGN_TRAP_EN defined: a half/word/dword access not aligned to its size issues no request.
  - It completes in one cycle with wb_misalign=1, wb_bad_addr=ex_alu_result, and wb_reg_write forced 0.
  - wb_misalign is 0 for all other instructions and on reset.
- Undefined: the wb_misalign and wb_bad_addr ports do not exist. Misaligned addresses have their low bits cleared to the size alignment and the access is performed normally.

## Structure
- Package mem_stage_pkg holds:
  - FSM state enum
  - size encodings (SZ_B, SZ_H, SZ_W, SZ_D)
  - PC_INCR=4
  - functions for byte-enable generation and store replication
- One sub-module, mem_load_align: combinational shift, truncate and extend of dmem_rdata, parametrised by XLEN.

## Test plan
- Reset, then LW at 0x010 with immediate ack and rdata 0xDEADBEEF -> next cycle wb_read_data=0xDEADBEEF, wb_valid=1, no stall.
- LB at 0x013 with rdata 0x80FFFFFF -> wb_read_data=0xFFFFFF80; LBU -> 0x00000080.
- SH at 0x006 with data 0x0000ABCD -> dmem_be=4'b1100, dmem_wdata=0xABCDABCD, dmem_we=1.
- LW with ack delayed 3 cycles -> mem_stall=1 for 3 cycles, 3 bubbles with wb_reg_write=0, result lands 4 cycles after issue.
- JAL with ex_pc=0x7FFC, no memory op -> wb_pc_plus4=0x00008000 next cycle.
- LW at 0x002: with MEM_MISALIGN_TRAP_EN -> dmem_req=0, wb_misalign=1, wb_bad_addr=0x002. Without it -> dmem_addr=0x000, dmem_be=4'b1111. Also cover reset mid-WAIT -> wb_valid=0 and no request afterwards.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage.
// Holds the MEM FSM state encoding, access-size encodings, the PC link
// increment and helper functions for byte-enable generation and store
// replication. The helpers work on a 64-bit datapath. Callers that use a
// 32-bit datapath truncate the result.
package mem_stage_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam int unsigned PC_INCR = 4;

  // Low address bits that must be zero for an access of the given size.
  function automatic logic [2:0] size_mask(input logic [1:0] size);
    logic [2:0] mask;
    case (size)
      SZ_B:    mask = 3'b000;
      SZ_H:    mask = 3'b001;
      SZ_W:    mask = 3'b011;
      SZ_D:    mask = 3'b111;
      default: mask = 3'b000;
    endcase
    return mask;
  endfunction

  // Consecutive byte lanes covered by an access of the given size, starting at lane.
  function automatic logic [7:0] byte_enables(input logic [1:0] size, input logic [2:0] lane);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      SZ_D:    base = 8'hFF;
      default: base = 8'h01;
    endcase
    return base << lane;
  endfunction

  // Copies the LSB-justified store data into every size-aligned slot of the bus.
  function automatic logic [63:0] store_replicate(input logic [63:0] data, input logic [1:0] size);
    logic [63:0] rep;
    case (size)
      SZ_B:    rep = {8{data[7:0]}};
      SZ_H:    rep = {4{data[15:0]}};
      SZ_W:    rep = {2{data[31:0]}};
      SZ_D:    rep = data;
      default: rep = data;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment for the memory-access stage.
// This block is purely combinational. It shifts the raw read data right by
// the byte lane, truncates it to the access size and then zero-extends or
// sign-extends the result.
// Ports:
//   rdata       : raw data-memory read bus
//   lane        : byte lane of the (aligned) access
//   size        : access size (SZ_B/SZ_H/SZ_W/SZ_D)
//   is_unsigned : 1 = zero-extend, 0 = sign-extend
//   data        : aligned and extended load value
module mem_load_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int LANE_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]   rdata,
  input  logic [LANE_W-1:0] lane,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [XLEN-1:0]   data
);

  logic [XLEN-1:0] shifted_s;

  // Move the addressed byte lane down to bit 0.
  always_comb begin
    shifted_s = rdata >> {lane, 3'b000};
  end

  // Truncate to the access size. A sized cast of a signed operand sign-extends.
  always_comb begin
    data = shifted_s;
    case (size)
      SZ_B:    data = is_unsigned ? XLEN'(shifted_s[7:0])  : XLEN'($signed(shifted_s[7:0]));
      SZ_H:    data = is_unsigned ? XLEN'(shifted_s[15:0]) : XLEN'($signed(shifted_s[15:0]));
      SZ_W:    data = is_unsigned ? XLEN'(shifted_s[31:0]) : XLEN'($signed(shifted_s[31:0]));
      SZ_D:    data = shifted_s;
      default: data = shifted_s;
    endcase
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// Memory-access stage and MEM/WB pipeline register of the five-stage core.
// The stage drives a handshaked data-memory port with byte enables and
// aligns and extends load data. It stalls upstream while memory is busy
// and registers all results for writeback, including PC+4 for JAL/JALR.
// XLEN must be 32 or 64. On a 32-bit datapath the dword size code is
// treated as a word access.
// Optional feature, enabled with the macro MEM_MISALIGN_TRAP_EN:
//   A misaligned half, word or dword access issues no request. It completes
//   at once and is reported on wb_misalign and wb_bad_addr. When the macro
//   is not defined, misaligned addresses are rounded down to the size
//   alignment.
// Ports:
//   clk, reset_n    : clock and asynchronous active-low reset
//   ex_*            : EXE/MEM slot, held stable by upstream while mem_stall=1
//   mem_stall       : freeze request to the upstream stages
//   dmem_*          : data-memory request/response handshake
//   wb_*            : registered MEM/WB outputs feeding writeback
module mem_wb_pipe
  import mem_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 11,
  parameter int PC_W   = 15,
  parameter int REG_W  = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ex_valid,
  input  logic                ex_mem_read,
  input  logic                ex_mem_write,
  input  logic [2:0]          ex_funct3,
  input  logic [XLEN-1:0]     ex_alu_result,
  input  logic [XLEN-1:0]     ex_write_data,
  input  logic [1:0]          ex_mem_to_reg,
  input  logic                ex_reg_write,
  input  logic [REG_W-1:0]    ex_rd,
  input  logic [PC_W-1:0]     ex_pc,
  output logic                mem_stall,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [XLEN/8-1:0]   dmem_be,
  output logic [XLEN-1:0]     dmem_wdata,
  input  logic [XLEN-1:0]     dmem_rdata,
  input  logic                dmem_ack,
  output logic                wb_valid,
  output logic                wb_reg_write,
  output logic [1:0]          wb_mem_to_reg,
  output logic [REG_W-1:0]    wb_rd,
  output logic [XLEN-1:0]     wb_read_data,
  output logic [XLEN-1:0]     wb_alu_result,
  output logic [XLEN-1:0]     wb_pc_plus4
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                wb_misalign,
  output logic [XLEN-1:0]     wb_bad_addr
`endif
);

  localparam int LANE_W = $clog2(XLEN / 8);
  localparam int BE_W   = XLEN / 8;

  mem_state_e        state_r;
  mem_state_e        state_n;
  logic [1:0]        size_s;
  logic [2:0]        amask_s;
  logic [LANE_W-1:0] lane_s;
  logic              misalign_s;
  logic              mem_op_s;
  logic              req_s;
  logic              stall_s;
  logic [XLEN-1:0]   load_data_s;
  logic [XLEN-1:0]   pc_plus4_s;

  // Decode the effective access size. A 32-bit datapath has no dword access.
  always_comb begin
    size_s = ex_funct3[1:0];
    if ((XLEN == 32) && (ex_funct3[1:0] == SZ_D)) begin
      size_s = SZ_W;
    end else begin
      size_s = ex_funct3[1:0];
    end
  end

  // Address alignment, lane selection and misalignment detection.
  always_comb begin
    amask_s = size_mask(size_s);
    lane_s  = ex_alu_result[LANE_W-1:0] & ~LANE_W'(amask_s);
`ifdef MEM_MISALIGN_TRAP_EN
    misalign_s = ex_valid & (ex_mem_read | ex_mem_write) & (|(ex_alu_result[2:0] & amask_s));
`else
    misalign_s = 1'b0;
`endif
  end

  // Request and stall generation.
  // Gating with reset_n drops a pending request as soon as reset is asserted.
  always_comb begin
    mem_op_s = ex_valid & (ex_mem_read | ex_mem_write) & ~misalign_s;
    req_s    = reset_n & ((state_r == ST_WAIT) | mem_op_s);
    stall_s  = req_s & ~dmem_ack;
  end

  // Data-memory port fields, rebuilt every cycle from the held ex_* inputs.
  always_comb begin
    dmem_req   = req_s;
    dmem_we    = req_s & ex_mem_write;
    dmem_addr  = ex_alu_result[ADDR_W-1:0] & ~ADDR_W'(amask_s);
    dmem_be    = req_s ? BE_W'(byte_enables(size_s, 3'(lane_s))) : {BE_W{1'b0}};
    dmem_wdata = XLEN'(store_replicate(64'(ex_write_data), size_s));
    mem_stall  = stall_s;
    pc_plus4_s = XLEN'(ex_pc) + XLEN'(PC_INCR);
  end

  mem_load_align #(
    .XLEN   (XLEN),
    .LANE_W (LANE_W)
  ) u_load_align (
    .rdata       (dmem_rdata),
    .lane        (lane_s),
    .size        (size_s),
    .is_unsigned (ex_funct3[2]),
    .data        (load_data_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // FSM next state: wait in WAIT until the memory acknowledges.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (mem_op_s && !dmem_ack) begin
          state_n = ST_WAIT;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (dmem_ack) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_WAIT;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // MEM/WB register: load results on a completing cycle, insert a bubble while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 2'b00;
      wb_rd         <= {REG_W{1'b0}};
      wb_read_data  <= {XLEN{1'b0}};
      wb_alu_result <= {XLEN{1'b0}};
      wb_pc_plus4   <= {XLEN{1'b0}};
`ifdef MEM_MISALIGN_TRAP_EN
      wb_misalign   <= 1'b0;
      wb_bad_addr   <= {XLEN{1'b0}};
`endif
    end else if (stall_s) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      wb_misalign   <= 1'b0;
`endif
    end else begin
      wb_valid      <= ex_valid;
      wb_reg_write  <= ex_valid & ex_reg_write & ~misalign_s;
      wb_mem_to_reg <= ex_mem_to_reg;
      wb_rd         <= ex_rd;
      wb_read_data  <= (mem_op_s & ex_mem_read) ? load_data_s : {XLEN{1'b0}};
      wb_alu_result <= ex_alu_result;
      wb_pc_plus4   <= pc_plus4_s;
`ifdef MEM_MISALIGN_TRAP_EN
      wb_misalign   <= misalign_s;
      wb_bad_addr   <= ex_alu_result;
`endif
    end
  end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench for mem_wb_pipe, using the default parameters (XLEN=32).
// Expected values come from a byte-level reference model of the access rules.
module tb_mem_wb_pipe;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 11;
  localparam int PC_W   = 15;
  localparam int REG_W  = 5;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              ex_valid = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0, ex_reg_write = 1'b0;
  logic [2:0]        ex_funct3 = 3'd0;
  logic [XLEN-1:0]   ex_alu_result = '0, ex_write_data = '0, dmem_rdata = '0;
  logic [1:0]        ex_mem_to_reg = 2'd0;
  logic [REG_W-1:0]  ex_rd = '0;
  logic [PC_W-1:0]   ex_pc = '0;
  logic              dmem_ack = 1'b0;
  logic              mem_stall, dmem_req, dmem_we, wb_valid, wb_reg_write;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0]        dmem_be;
  logic [XLEN-1:0]   dmem_wdata, wb_read_data, wb_alu_result, wb_pc_plus4;
  logic [1:0]        wb_mem_to_reg;
  logic [REG_W-1:0]  wb_rd;
`ifdef MEM_MISALIGN_TRAP_EN
  logic              wb_misalign;
  logic [XLEN-1:0]   wb_bad_addr;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_pipe #(.XLEN(XLEN), .ADDR_W(ADDR_W), .PC_W(PC_W), .REG_W(REG_W)) dut (
    .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result),
    .ex_write_data(ex_write_data), .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
    .ex_rd(ex_rd), .ex_pc(ex_pc), .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd), .wb_read_data(wb_read_data),
    .wb_alu_result(wb_alu_result), .wb_pc_plus4(wb_pc_plus4)
`ifdef MEM_MISALIGN_TRAP_EN
    , .wb_misalign(wb_misalign), .wb_bad_addr(wb_bad_addr)
`endif
  );

  // ---------------- reference model (byte-level) ----------------
  function automatic int nb(input logic [1:0] sz);
    if (sz == 2'd0) return 1;
    else if (sz == 2'd1) return 2;
    else return 4;
  endfunction

  function automatic logic exp_mis(input logic v, input logic r, input logic w,
                                   input logic [31:0] a, input logic [2:0] f3);
`ifdef MEM_MISALIGN_TRAP_EN
    return v && (r || w) && ((int'(a[1:0]) % nb(f3[1:0])) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int lane_of(input logic [31:0] a, input logic [2:0] f3);
    int n = nb(f3[1:0]);
    return (int'(a[1:0]) / n) * n;
  endfunction

  function automatic logic [10:0] exp_addr(input logic [31:0] a, input logic [2:0] f3);
    int n = nb(f3[1:0]);
    int x = int'(a[10:0]);
    return 11'(x - (x % n));
  endfunction

  function automatic logic [3:0] exp_be(input logic [31:0] a, input logic [2:0] f3);
    int n = nb(f3[1:0]);
    int l = lane_of(a, f3);
    logic [3:0] be = 4'b0000;
    for (int i = 0; i < 4; i++) if (i >= l && i < l + n) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] d, input logic [2:0] f3);
    int n = nb(f3[1:0]);
    logic [31:0] r = 32'd0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [31:0] a, input logic [2:0] f3);
    int n = nb(f3[1:0]);
    int l = lane_of(a, f3);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(l + i) +: 8];
    if (!f3[2] && n < 4 && v[8*n-1]) v = v - (32'd1 << (8*n));
    return v;
  endfunction

  task automatic drive(input logic v, input logic r, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [1:0] m2r,
                       input logic rw, input logic [4:0] rdi, input logic [14:0] pc);
    ex_valid = v; ex_mem_read = r; ex_mem_write = w; ex_funct3 = f3; ex_alu_result = a;
    ex_write_data = wd; ex_mem_to_reg = m2r; ex_reg_write = rw; ex_rd = rdi; ex_pc = pc;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 2'd0, 1'b0, 5'd0, 15'd0);
    dmem_ack = 1'b0;
    step(); step();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
    checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL reset_wb_reg_write got %b exp 0", wb_reg_write); end
    checks++; if (wb_read_data !== 32'd0 || wb_alu_result !== 32'd0 || wb_pc_plus4 !== 32'd0)
      begin errors++; $display("FAIL reset_wb_data got %h %h %h exp 0", wb_read_data, wb_alu_result, wb_pc_plus4); end
    checks++; if (wb_rd !== 5'd0 || wb_mem_to_reg !== 2'd0) begin errors++; $display("FAIL reset_wb_ctl got %h %h exp 0", wb_rd, wb_mem_to_reg); end
    checks++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL reset_req got %b stall %b exp 0", dmem_req, mem_stall); end
`ifdef MEM_MISALIGN_TRAP_EN
    checks++; if (wb_misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b exp 0", wb_misalign); end
`endif
    @(negedge clk); reset_n = 1'b1;
    step();
  endtask

  task automatic test_loads;
    logic [2:0]  f3_t [3] = '{3'b010, 3'b000, 3'b100};
    logic [31:0] a_t  [3] = '{32'h010, 32'h013, 32'h013};
    logic [31:0] rd_t [3] = '{32'hDEADBEEF, 32'h80FFFFFF, 32'h80FFFFFF};
    logic [31:0] ex_t [3] = '{32'hDEADBEEF, 32'hFFFFFF80, 32'h00000080};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, f3_t[i], a_t[i], 32'd0, 2'd1, 1'b1, 5'(i + 3), 15'h100);
      dmem_ack = 1'b1; dmem_rdata = rd_t[i];
      @(negedge clk);
      checks++; if (dmem_req !== 1'b1 || mem_stall !== 1'b0 || dmem_we !== 1'b0)
        begin errors++; $display("FAIL load%0d_req got req %b stall %b we %b exp 1 0 0", i, dmem_req, mem_stall, dmem_we); end
      checks++; if (dmem_addr !== exp_addr(a_t[i], f3_t[i])) begin errors++; $display("FAIL load%0d_addr got %h exp %h", i, dmem_addr, exp_addr(a_t[i], f3_t[i])); end
      step();
      checks++; if (wb_read_data !== ex_t[i]) begin errors++; $display("FAIL load%0d_data got %h exp %h", i, wb_read_data, ex_t[i]); end
      checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b1 || wb_rd !== 5'(i + 3))
        begin errors++; $display("FAIL load%0d_wb got v %b rw %b rd %0d exp 1 1 %0d", i, wb_valid, wb_reg_write, wb_rd, i + 3); end
    end
  endtask

  task automatic test_store;
    drive(1'b1, 1'b0, 1'b1, 3'b001, 32'h006, 32'h0000ABCD, 2'd0, 1'b0, 5'd0, 15'h104);
    dmem_ack = 1'b1;
    @(negedge clk);
    checks++; if (dmem_be !== 4'b1100) begin errors++; $display("FAIL sh_be got %b exp 1100", dmem_be); end
    checks++; if (dmem_wdata !== 32'hABCDABCD) begin errors++; $display("FAIL sh_wdata got %h exp abcdabcd", dmem_wdata); end
    checks++; if (dmem_we !== 1'b1 || dmem_req !== 1'b1) begin errors++; $display("FAIL sh_we got we %b req %b exp 1 1", dmem_we, dmem_req); end
    step();
    checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0) begin errors++; $display("FAIL sh_wb got v %b rw %b exp 1 0", wb_valid, wb_reg_write); end
  endtask

  task automatic test_wait_states;
    int stalls = 0;
    int bubbles = 0;
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h020, 32'd0, 2'd1, 1'b1, 5'd9, 15'h108);
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_stall === 1'b1 && dmem_req === 1'b1) stalls++;
      step();
      if (wb_valid === 1'b0 && wb_reg_write === 1'b0) bubbles++;
    end
    checks++; if (stalls != 3) begin errors++; $display("FAIL wait_stall_cycles got %0d exp 3", stalls); end
    checks++; if (bubbles != 3) begin errors++; $display("FAIL wait_bubbles got %0d exp 3", bubbles); end
    dmem_ack = 1'b1; dmem_rdata = 32'h11223344;
    @(negedge clk);
    checks++; if (mem_stall !== 1'b0 || dmem_req !== 1'b1) begin errors++; $display("FAIL wait_ack_cycle got stall %b req %b exp 0 1", mem_stall, dmem_req); end
    step();
    checks++; if (wb_valid !== 1'b1 || wb_read_data !== 32'h11223344 || wb_rd !== 5'd9)
      begin errors++; $display("FAIL wait_result got v %b data %h rd %0d exp 1 11223344 9", wb_valid, wb_read_data, wb_rd); end
  endtask

  task automatic test_jal;
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h1234, 32'd0, 2'd2, 1'b1, 5'd1, 15'h7FFC);
    dmem_ack = 1'b1;  // stray ack with no request must be ignored
    @(negedge clk);
    checks++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL jal_req got req %b stall %b exp 0 0", dmem_req, mem_stall); end
    step();
    checks++; if (wb_pc_plus4 !== 32'h00008000) begin errors++; $display("FAIL jal_pc4 got %h exp 00008000", wb_pc_plus4); end
    checks++; if (wb_valid !== 1'b1 || wb_mem_to_reg !== 2'd2 || wb_alu_result !== 32'h1234)
      begin errors++; $display("FAIL jal_wb got v %b m2r %0d alu %h exp 1 2 1234", wb_valid, wb_mem_to_reg, wb_alu_result); end
  endtask

  task automatic test_misalign;
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h002, 32'd0, 2'd1, 1'b1, 5'd7, 15'h10C);
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    @(negedge clk);
`ifdef MEM_MISALIGN_TRAP_EN
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL mis_req got %b exp 0", dmem_req); end
    step();
    checks++; if (wb_misalign !== 1'b1 || wb_bad_addr !== 32'h002) begin errors++; $display("FAIL mis_trap got %b %h exp 1 00000002", wb_misalign, wb_bad_addr); end
    checks++; if (wb_reg_write !== 1'b0 || wb_valid !== 1'b1) begin errors++; $display("FAIL mis_wb got rw %b v %b exp 0 1", wb_reg_write, wb_valid); end
`else
    checks++; if (dmem_req !== 1'b1 || dmem_addr !== 11'h000 || dmem_be !== 4'b1111)
      begin errors++; $display("FAIL mis_align got req %b addr %h be %b exp 1 000 1111", dmem_req, dmem_addr, dmem_be); end
    step();
    checks++; if (wb_read_data !== 32'hCAFEF00D || wb_reg_write !== 1'b1) begin errors++; $display("FAIL mis_wb got %h rw %b exp cafef00d 1", wb_read_data, wb_reg_write); end
`endif
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 5; i++) begin
      logic [31:0] a = {20'd0, 10'($urandom), 2'b00};
      logic [31:0] rd = $urandom;
      drive(1'b1, 1'b1, 1'b0, 3'b010, a, 32'd0, 2'd1, 1'b1, 5'(10 + i), 15'(i * 4));
      dmem_ack = 1'b1; dmem_rdata = rd;
      @(negedge clk);
      checks++; if (mem_stall !== 1'b0 || dmem_req !== 1'b1) begin errors++; $display("FAIL b2b%0d_issue got stall %b req %b exp 0 1", i, mem_stall, dmem_req); end
      step();
      checks++; if (wb_valid !== 1'b1 || wb_read_data !== rd || wb_rd !== 5'(10 + i))
        begin errors++; $display("FAIL b2b%0d_wb got v %b data %h rd %0d exp 1 %h %0d", i, wb_valid, wb_read_data, wb_rd, rd, 10 + i); end
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 300; k++) begin
      logic v = ($urandom_range(0, 7) != 0);
      int kind = $urandom_range(0, 2);
      logic r = (kind == 0);
      logic w = (kind == 1);
      logic [2:0] f3 = {1'($urandom), 2'($urandom_range(0, 2))};
      logic [31:0] a = $urandom;
      logic [31:0] wd = $urandom;
      logic [31:0] rdat = $urandom;
      logic [14:0] pc = 15'($urandom);
      logic rw = 1'($urandom);
      logic [4:0] rdi = 5'($urandom);
      logic [1:0] m2r = 2'($urandom);
      logic mis = exp_mis(v, r, w, a, f3);
      logic req = v && (r || w) && !mis;
      int dly = req ? $urandom_range(0, 3) : 0;
      drive(v, r, w, f3, a, wd, m2r, rw, rdi, pc);
      for (int c = 0; c < dly; c++) begin
        dmem_ack = 1'b0; dmem_rdata = $urandom;
        @(negedge clk);
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL rnd%0d_stall got %b exp 1", k, mem_stall); end
        step();
        checks++; if (wb_valid !== 1'b0 || wb_reg_write !== 1'b0) begin errors++; $display("FAIL rnd%0d_bubble got v %b rw %b exp 0 0", k, wb_valid, wb_reg_write); end
      end
      dmem_ack = req ? 1'b1 : 1'($urandom); dmem_rdata = rdat;
      @(negedge clk);
      checks++; if (dmem_req !== req || mem_stall !== 1'b0) begin errors++; $display("FAIL rnd%0d_req got req %b stall %b exp %b 0", k, dmem_req, mem_stall, req); end
      if (req) begin
        checks++; if (dmem_addr !== exp_addr(a, f3) || dmem_be !== exp_be(a, f3) || dmem_we !== w)
          begin errors++; $display("FAIL rnd%0d_port got addr %h be %b we %b exp %h %b %b", k, dmem_addr, dmem_be, dmem_we, exp_addr(a, f3), exp_be(a, f3), w); end
        if (w) begin
          checks++; if (dmem_wdata !== exp_wdata(wd, f3)) begin errors++; $display("FAIL rnd%0d_wdata got %h exp %h", k, dmem_wdata, exp_wdata(wd, f3)); end
        end
      end
      step();
      checks++; if (wb_valid !== v || wb_reg_write !== (v && rw && !mis))
        begin errors++; $display("FAIL rnd%0d_wbctl got v %b rw %b exp %b %b", k, wb_valid, wb_reg_write, v, v && rw && !mis); end
      checks++; if (wb_rd !== rdi || wb_mem_to_reg !== m2r || wb_alu_result !== a || wb_pc_plus4 !== (32'(pc) + 32'd4))
        begin errors++; $display("FAIL rnd%0d_wbpass got rd %0d m2r %0d alu %h pc4 %h exp %0d %0d %h %h", k, wb_rd, wb_mem_to_reg, wb_alu_result, wb_pc_plus4, rdi, m2r, a, 32'(pc) + 32'd4); end
      if (req && r) begin
        checks++; if (wb_read_data !== exp_load(rdat, a, f3)) begin errors++; $display("FAIL rnd%0d_load f3 %b got %h exp %h", k, f3, wb_read_data, exp_load(rdat, a, f3)); end
      end
`ifdef MEM_MISALIGN_TRAP_EN
      checks++; if (wb_misalign !== mis) begin errors++; $display("FAIL rnd%0d_mis got %b exp %b", k, wb_misalign, mis); end
`endif
    end
  endtask

  task automatic test_reset_mid_wait;
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h040, 32'd0, 2'd1, 1'b1, 5'd4, 15'h200);
    dmem_ack = 1'b0;
    step();
    checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL rmw_stall got %b exp 1", mem_stall); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rmw_drop got req %b exp 0", dmem_req); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rmw_wb got v %b exp 0", wb_valid); end
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 2'd0, 1'b0, 5'd0, 15'd0);
    @(negedge clk); reset_n = 1'b1;
    step();
    dmem_ack = 1'b1; dmem_rdata = 32'hBADBAD00;  // late ack for the dropped request
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL rmw_late%0d got req %b stall %b exp 0 0", c, dmem_req, mem_stall); end
      step();
      checks++; if (wb_valid !== 1'b0 || wb_reg_write !== 1'b0) begin errors++; $display("FAIL rmw_wb%0d got v %b rw %b exp 0 0", c, wb_valid, wb_reg_write); end
    end
    dmem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_loads();
    test_store();
    test_wait_states();
    test_jal();
    test_misalign();
    test_back_to_back();
    test_random();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
